// File: rtl/sm_to_twos_serial_if.sv
// Handshake/data bundle for the serial sign-magnitude to two's-complement converter.
// Optional neg_zero flag is present only when NEG_ZERO_FLAG_EN is defined.
interface sm_to_twos_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
`ifdef NEG_ZERO_FLAG_EN
    logic             neg_zero;

    modport master (output start, din, input busy, done, dout, neg_zero);
    modport slave  (input start, din, output busy, done, dout, neg_zero);
`else
    modport master (output start, din, input busy, done, dout);
    modport slave  (input start, din, output busy, done, dout);
`endif
endinterface

// File: rtl/sm_to_twos_serial.sv
// Bit-serial sign-magnitude -> two's-complement converter, one magnitude bit per clock.
// Optional macro NEG_ZERO_FLAG_EN adds a registered neg_zero flag on the interface.
module sm_to_twos_serial #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    sm_to_twos_serial_if.slave     bus
);
    localparam int MW = WIDTH - 1;
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   mag_q, mag_d;
    logic            sign_q, sign_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [MW-1:0]   res_q, res_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic            nz_q, nz_d;

    logic            last_bit;
    logic            r_bit;
    logic            carry_nx;
    logic [MW-1:0]   res_shift;

    assign last_bit = (idx_q == IW'(WIDTH - 2));

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CONV;
            CONV:    if (last_bit)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // output logic
    always_comb begin
        bus.busy = (state_q == CONV);
        bus.done = (state_q == DONE);
    end

    // Single inverter/half-adder slice; the magnitude shifts right so bit 0 is always current.
    always_comb begin
        r_bit    = sign_q ? (~mag_q[0] ^ carry_q) : mag_q[0];
        carry_nx = sign_q ? (~mag_q[0] & carry_q) : carry_q;
        res_shift         = res_q >> 1;
        res_shift[MW-1]   = r_bit;
    end

    always_comb begin
        mag_d   = mag_q;
        sign_d  = sign_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        res_d   = res_q;
        dout_d  = dout_q;
        nz_d    = nz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mag_d   = bus.din[MW-1:0];
                    sign_d  = bus.din[WIDTH-1];
                    idx_d   = '0;
                    carry_d = 1'b1;
                    res_d   = '0;
                end
            end
            CONV: begin
                mag_d   = mag_q >> 1;
                idx_d   = idx_q + IW'(1);
                carry_d = carry_nx;
                res_d   = res_shift;
                // Whole word written at once so dout is never partially updated.
                if (last_bit) begin
                    dout_d = {sign_q & ~carry_nx, res_shift};
                    nz_d   = sign_q & carry_nx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q   <= '0;
            sign_q  <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            dout_q  <= '0;
            nz_q    <= 1'b0;
        end else begin
            mag_q   <= mag_d;
            sign_q  <= sign_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            dout_q  <= dout_d;
            nz_q    <= nz_d;
        end
    end

    assign bus.dout = dout_q;
`ifdef NEG_ZERO_FLAG_EN
    assign bus.neg_zero = nz_q;
`else
    logic unused_nz;
    assign unused_nz = nz_q;
`endif
endmodule

// File: tb/tb_sm_to_twos_serial.sv
// Directed + random bench for sm_to_twos_serial at WIDTH=8 and WIDTH=4.
// Reference: two's-complement value computed arithmetically from sign and magnitude.
module tb_sm_to_twos_serial;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    sm_to_twos_serial_if #(.WIDTH(8)) b8 ();
    sm_to_twos_serial_if #(.WIDTH(4)) b4 ();

    sm_to_twos_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    sm_to_twos_serial #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    function automatic logic [31:0] ref_conv(input logic [31:0] d, input int w);
        longint mag, res, modv;
        modv = longint'(1) << w;
        mag  = longint'(d) & ((longint'(1) << (w - 1)) - 1);
        if (d[w-1]) res = (modv - mag) % modv;
        else        res = mag;
        return 32'(res);
    endfunction

    function automatic logic ref_nz(input logic [31:0] d, input int w);
        return d[w-1] && ((d & ((32'd1 << (w - 1)) - 32'd1)) == 32'd0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [31:0] d);
        if (w == 8) begin b8.start = s; b8.din = d[7:0]; end
        else        begin b4.start = s; b4.din = d[3:0]; end
    endtask

    function automatic logic get_done(input int w);
        return (w == 8) ? b8.done : b4.done;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 8) ? b8.busy : b4.busy;
    endfunction
    function automatic logic [31:0] get_dout(input int w);
        return (w == 8) ? 32'(b8.dout) : 32'(b4.dout);
    endfunction

    // e = edges after the start edge until done is seen; bc = cycles with busy high.
    task automatic conv(input int w, input logic [31:0] d, output int e, output int bc);
        @(negedge clk); drive(w, 1'b1, d);
        @(posedge clk);
        @(negedge clk); drive(w, 1'b0, $urandom);
        e = 0; bc = 0;
        while (!get_done(w) && e < 40) begin
            if (get_busy(w)) bc++;
            @(posedge clk); @(negedge clk);
            e++;
        end
        chk("done_timeout", 32'(e < 40), 32'd1);
        chk("busy_with_done", 32'(get_busy(w)), 32'd0);
    endtask

    initial begin
        int e, bc, cnt, prev, cyc, k;
        logic [31:0] d;
        logic [7:0]  dir_in  [5] = '{8'h85, 8'hFF, 8'h7F, 8'h80, 8'h81};
        logic [7:0]  dir_out [5] = '{8'hFB, 8'h81, 8'h7F, 8'h00, 8'hFF};
        logic [3:0]  b2b     [3] = '{4'b1011, 4'b0110, 4'b1000};

        rst = 1'b1;
        drive(8, 1'b0, 0);
        drive(4, 1'b0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy8", 32'(b8.busy), 0);
        chk("rst_done8", 32'(b8.done), 0);
        chk("rst_dout8", 32'(b8.dout), 0);
        chk("rst_dout4", 32'(b4.dout), 0);
`ifdef NEG_ZERO_FLAG_EN
        chk("rst_nz8", 32'(b8.neg_zero), 0);
`endif
        rst = 1'b0;

        conv(8, 32'h05, e, bc);
        chk("lat_05", e, 7);
        chk("busy_cnt_05", bc, 7);
        chk("dout_05", get_dout(8), 32'h05);
        @(negedge clk);
        chk("done_pulse_one_cycle", 32'(b8.done), 0);

        for (int i = 0; i < 5; i++) begin
            conv(8, 32'(dir_in[i]), e, bc);
            chk($sformatf("dir_dout_%0h", dir_in[i]), get_dout(8), 32'(dir_out[i]));
`ifdef NEG_ZERO_FLAG_EN
            chk($sformatf("dir_nz_%0h", dir_in[i]), 32'(b8.neg_zero), 32'(dir_in[i] == 8'h80));
`endif
        end

        // second start while busy is dropped; dout holds old value until DONE
        @(negedge clk); drive(8, 1'b1, 32'h83);
        @(posedge clk);
        @(negedge clk); drive(8, 1'b0, 32'h83);
        @(posedge clk); @(posedge clk);
        @(negedge clk); drive(8, 1'b1, 32'h01);
        chk("dout_held_in_conv", 32'(b8.dout), 32'hFF);
        @(posedge clk);
        @(negedge clk); drive(8, 1'b0, 32'h01);
        cnt = 0;
        repeat (15) begin
            if (b8.done) cnt++;
            @(posedge clk); @(negedge clk);
        end
        chk("ignored_start_done_cnt", cnt, 1);
        chk("ignored_start_dout", 32'(b8.dout), 32'hFD);

        // reset mid-conversion
        @(negedge clk); drive(8, 1'b1, 32'h85);
        @(posedge clk);
        @(negedge clk); drive(8, 1'b0, 32'h85);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", 32'(b8.busy), 0);
        chk("midrst_dout", 32'(b8.dout), 0);
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            if (b8.done) cnt++;
            @(posedge clk); @(negedge clk);
        end
        chk("midrst_no_done", cnt, 0);
        conv(8, 32'h02, e, bc);
        chk("after_rst_lat", e, 7);
        chk("after_rst_dout", get_dout(8), 32'h02);

        for (int i = 0; i < 16; i++) begin
            d = 32'($urandom_range(0, 255));
            conv(8, d, e, bc);
            chk($sformatf("rnd8_dout_%0h", d[7:0]), get_dout(8), ref_conv(d, 8));
            chk("rnd8_lat", e, 7);
`ifdef NEG_ZERO_FLAG_EN
            chk("rnd8_nz", 32'(b8.neg_zero), 32'(ref_nz(d, 8)));
`endif
        end

        conv(4, 32'b1011, e, bc);
        chk("w4_lat", e, 3);
        chk("w4_dout", get_dout(4), 32'b1101);

        // back-to-back: start held high, din advanced when done is seen
        @(negedge clk); drive(4, 1'b1, 32'(b2b[0]));
        k = 0; cyc = 0; prev = 0;
        while (k < 3 && cyc < 60) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (b4.done) begin
                chk($sformatf("b2b_dout_%0d", k), get_dout(4), ref_conv(32'(b2b[k]), 4));
                if (k == 0) chk("b2b_first_lat", cyc, 4);
                else        chk($sformatf("b2b_interval_%0d", k), cyc - prev, 5);
                prev = cyc;
                k++;
                if (k < 3) drive(4, 1'b1, 32'(b2b[k]));
            end
        end
        chk("b2b_count", k, 3);
        drive(4, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            d = 32'($urandom_range(0, 15));
            conv(4, d, e, bc);
            chk($sformatf("rnd4_dout_%0h", d[3:0]), get_dout(4), ref_conv(d, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
